// File: rtl/poets_system_cpu_cpu_ocimem_ctrl.sv
// poets_system_cpu_cpu_ocimem_ctrl: arbitrates the OCI debug RAM between JTAG commands and the CPU debug slave
module poets_system_cpu_cpu_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              mon_valid,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [1:0] {IDLE, J_RD, C_RD} state_t;
  typedef enum logic [1:0] {K_ADR, K_ARD, K_WR, K_NRD} kind_t;
  state_t            state;
  kind_t             slot_k, in_k, jk;
  logic              slot_v, in_v, jp, serve, drop;
  logic [31:0]       slot_d, jd;
  logic [ADDR_W-1:0] mon_a;
  logic              unused;
  assign unused = ^{jdo[37:36], jdo[2:0]};
  // Pick the JTAG command to serve (a waiting slot beats a fresh strobe) and steer the RAM port
  always_comb begin
    in_v = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    in_k = take_action_ocimem_a ? (jdo[35] ? K_ARD : K_ADR) : take_action_ocimem_b ? K_WR : K_NRD;
    drop = (take_action_ocimem_a & take_action_ocimem_b) | (take_action_ocimem_a & take_no_action_ocimem_a)
         | (take_action_ocimem_b & take_no_action_ocimem_a) | (in_v & slot_v);
    jp = slot_v | in_v;
    jk = slot_v ? slot_k : in_k;
    jd = slot_v ? slot_d : jdo[34:3];
    serve = !reset && state == IDLE && jp;
    ram_addr = serve ? (jk == K_ARD || jk == K_ADR ? jd[14 +: ADDR_W] : mon_a) : avs_address;
    ram_wdata = serve ? jd : avs_writedata;
    ram_we = !reset && state == IDLE && (jp ? jk == K_WR : avs_write);
    avs_waitrequest = (avs_read | avs_write) && (reset || !(state == C_RD || (state == IDLE && !jp && avs_write)));
    avs_readdata = ram_rdata;
  end
  // Command slot, monitor address/data registers and the IDLE/J_RD/C_RD sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mon_a <= '0;
      MonDReg <= '0;
      mon_valid <= 1'b0;
      slot_v <= 1'b0;
      slot_k <= K_ADR;
      slot_d <= '0;
      jtag_overrun <= 1'b0;
    end else begin
      mon_valid <= state == J_RD;
      if (drop) jtag_overrun <= 1'b1;
      if (serve) slot_v <= 1'b0;
      else if (in_v && !slot_v) begin
        slot_v <= 1'b1;
        slot_k <= in_k;
        slot_d <= jdo[34:3];
      end
      if (state == J_RD) begin
        MonDReg <= ram_rdata;
        mon_a <= mon_a + 1'b1;
      end
      if (serve) mon_a <= jk == K_WR ? mon_a + 1'b1 : jk == K_NRD ? mon_a : jd[14 +: ADDR_W];
      state <= state != IDLE ? IDLE :
               serve ? (jk == K_ARD || jk == K_NRD ? J_RD : IDLE) :
               (avs_read && !avs_write) ? C_RD : IDLE;
    end
  end
endmodule
